wb_pwm_fader: RTL and testbench

Wishbone-controlled fade sequencer that drives the `wb_pwm` duty-cycle registers. Software writes a target duty cycle per channel and a step period. The block then walks each channel's current duty cycle one LSB per period toward its target. Every change is pushed to `wb_pwm` through its own Wishbone B4 pipelined master port. It sits between the system bus (slave side) and one `wb_pwm` instance (master side), sharing its `BITS`/`CHANNELS` parameters.

---
 rtl/wb_pwm_pkg.sv | 32 +++
 rtl/wb_pwm_fader_presc.sv | 34 +++
 rtl/wb_pwm_fader.sv | 230 +++++++++++++++++++++++
 tb/tb_wb_pwm_fader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pwm_pkg.sv
// Shared definitions for the wb_pwm fade sequencer: FSM states, register
// offsets relative to the channel count, and the duty-cycle clamp.
package wb_pwm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_REQ  = 2'd2,
      ST_WAIT = 2'd3
   } fsm_state_e;

   // Control registers sit directly above the per-channel target registers.
   function automatic logic [31:0] adr_div(input int channels);
      return 32'(channels);
   endfunction

   function automatic logic [31:0] adr_ctrl(input int channels);
      return 32'(channels + 1);
   endfunction

   function automatic logic [31:0] adr_status(input int channels);
      return 32'(channels + 2);
   endfunction

   // 100% duty in wb_pwm is 1<<(bits-1); anything larger saturates there.
   function automatic logic [31:0] clamp_duty(input logic [31:0] value, input int bits);
      logic [31:0] full;
      full = 32'd1 << (bits - 1);
      return (value > full) ? full : value;
   endfunction

endpackage

// File: rtl/wb_pwm_fader_presc.sv
// Step-period prescaler: counts 0..div_i while enabled and emits a one-cycle
// tick on the terminal count, giving a period of div_i+1 cycles.
module wb_pwm_fader_presc #(
   parameter int DIV_BITS = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                en_i,
   input  logic [DIV_BITS-1:0] div_i,
   output logic                tick_o
);

   logic [DIV_BITS-1:0] cnt_q;
   logic [DIV_BITS-1:0] cnt_d;

   // >= keeps the period sane when DIV is lowered below the running count.
   assign tick_o = en_i && (cnt_q >= div_i);

   always_comb begin
      cnt_d = cnt_q + DIV_BITS'(1);
      if (!en_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_pwm_fader.sv
// Wishbone fade sequencer: walks each channel's duty one LSB per step period
// toward its target and pushes every change to wb_pwm over a master port.
// Optional slave readback is enabled by defining WB_PWM_FADER_READBACK_EN.
module wb_pwm_fader
   import wb_pwm_pkg::*;
#(
   parameter int BITS     = 4,
   parameter int CHANNELS = 3,
   parameter int DIV_BITS = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_stall_o,
   output logic        pwm_cyc_o,
   output logic        pwm_stb_o,
   output logic        pwm_we_o,
   output logic [31:0] pwm_adr_o,
   output logic [31:0] pwm_dat_o,
   input  logic        pwm_ack_i,
   input  logic        pwm_stall_i,
   output logic        busy_o
);

   localparam int              IDXW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHANNELS - 1);
   localparam logic [31:0]     ADR_DIV  = adr_div(CHANNELS);
   localparam logic [31:0]     ADR_CTRL = adr_ctrl(CHANNELS);

   logic                slv_req;
   logic                slv_wr;
   logic [BITS-1:0]     tgt_wdat;
   logic                ack_q;
   logic                en_q;
   logic [DIV_BITS-1:0] div_q;
   logic                tick;

   assign slv_req    = wb_cyc_i & wb_stb_i;
   assign slv_wr     = slv_req & wb_we_i;
   assign tgt_wdat   = BITS'(clamp_duty(wb_dat_i, BITS));
   assign wb_ack_o   = ack_q;
   assign wb_stall_o = 1'b0;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         ack_q <= 1'b0;
         en_q  <= 1'b0;
         div_q <= '0;
      end else begin
         ack_q <= slv_req;
         if (slv_wr && (wb_adr_i == ADR_DIV)) begin
            div_q <= wb_dat_i[DIV_BITS-1:0];
         end
         if (slv_wr && (wb_adr_i == ADR_CTRL)) begin
            en_q <= wb_dat_i[0];
         end
      end
   end

   wb_pwm_fader_presc #(
      .DIV_BITS (DIV_BITS)
   ) u_presc (
      .clk_i  (wb_clk_i),
      .rst_ni (wb_rst_ni),
      .en_i   (en_q),
      .div_i  (div_q),
      .tick_o (tick)
   );

   fsm_state_e      state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [IDXW-1:0] adr_q, adr_d;
   logic [BITS-1:0] dat_q, dat_d;
   logic            pend_q, pend_d;
   logic            step_we;
   logic [BITS-1:0] step_val;
   logic [BITS-1:0] cur_sel;
   logic [BITS-1:0] tgt_sel;

   logic [CHANNELS-1:0][BITS-1:0] cur_w;
   logic [CHANNELS-1:0][BITS-1:0] tgt_w;
   logic [CHANNELS-1:0]           ne_w;

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [BITS-1:0] cur_q;
      logic [BITS-1:0] tgt_q;

      always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
         if (!wb_rst_ni) begin
            cur_q <= '0;
            tgt_q <= '0;
         end else begin
            if (slv_wr && (wb_adr_i == 32'(gi))) begin
               tgt_q <= tgt_wdat;
            end
            if (step_we && (idx_q == IDXW'(gi))) begin
               cur_q <= step_val;
            end
         end
      end

      assign cur_w[gi] = cur_q;
      assign tgt_w[gi] = tgt_q;
      assign ne_w[gi]  = (cur_q != tgt_q);
   end

   assign busy_o   = |ne_w;
   assign cur_sel  = cur_w[idx_q];
   assign tgt_sel  = tgt_w[idx_q];
   assign step_val = (cur_sel < tgt_sel) ? (cur_sel + BITS'(1)) : (cur_sel - BITS'(1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      pend_d  = pend_q;
      step_we = 1'b0;

      // Only one tick is remembered while a scan is running; extra ones are dropped.
      if (tick && (state_q != ST_IDLE)) begin
         pend_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (en_q && (tick || pend_q)) begin
               state_d = ST_SCAN;
               idx_d   = '0;
               pend_d  = 1'b0;
            end
         end
         ST_SCAN: begin
            if (cur_sel != tgt_sel) begin
               step_we = 1'b1;
               adr_d   = idx_q;
               dat_d   = step_val;
               state_d = ST_REQ;
            end else if (idx_q == LAST_IDX) begin
               state_d = ST_IDLE;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         ST_REQ: begin
            if (!pwm_stall_i) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (pwm_ack_i) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_SCAN;
                  idx_d   = idx_q + IDXW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         adr_q   <= '0;
         dat_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         pend_q  <= pend_d;
      end
   end

   // Decoded straight from the state register so reset clears them at once.
   assign pwm_cyc_o = (state_q == ST_REQ) || (state_q == ST_WAIT);
   assign pwm_stb_o = (state_q == ST_REQ);
   assign pwm_we_o  = pwm_cyc_o;
   assign pwm_adr_o = 32'(adr_q);
   assign pwm_dat_o = 32'(dat_q);

`ifdef WB_PWM_FADER_READBACK_EN
   localparam logic [31:0] ADR_STATUS = adr_status(CHANNELS);

   logic [31:0] rd_d;
   logic [31:0] rd_q;

   always_comb begin
      rd_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (wb_adr_i == 32'(i)) begin
            rd_d[2*BITS-1:0] = {cur_w[i], tgt_w[i]};
         end
      end
      if (wb_adr_i == ADR_DIV) begin
         rd_d[DIV_BITS-1:0] = div_q;
      end
      if (wb_adr_i == ADR_CTRL) begin
         rd_d[0] = en_q;
      end
      if (wb_adr_i == ADR_STATUS) begin
         rd_d[0] = busy_o;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         rd_q <= '0;
      end else begin
         rd_q <= slv_req ? rd_d : '0;
      end
   end

   assign wb_dat_o = rd_q;
`else
   assign wb_dat_o = '0;
`endif

endmodule

// File: tb/tb_wb_pwm_fader.sv
// Self-checking bench for wb_pwm_fader: directed vector table, stall/reset
// sequences, and randomized fades checked against a per-step reference model.
module tb_wb_pwm_fader;
   import wb_pwm_pkg::*;

   localparam int BITS = 4;
   localparam int CH   = 3;
   localparam int FULL = 1 << (BITS - 1);

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_cyc, wb_stb, wb_we;
   logic [31:0] wb_adr, wb_dat_w;
   logic [31:0] wb_dat_r;
   logic        wb_ack, wb_stall;
   logic        pwm_cyc, pwm_stb, pwm_we;
   logic [31:0] pwm_adr, pwm_dat;
   logic        pwm_ack, pwm_stall;
   logic        busy;

   wb_pwm_fader #(.BITS(BITS), .CHANNELS(CH), .DIV_BITS(16)) dut (
      .wb_clk_i   (clk),
      .wb_rst_ni  (rst_n),
      .wb_cyc_i   (wb_cyc),
      .wb_stb_i   (wb_stb),
      .wb_we_i    (wb_we),
      .wb_adr_i   (wb_adr),
      .wb_dat_i   (wb_dat_w),
      .wb_dat_o   (wb_dat_r),
      .wb_ack_o   (wb_ack),
      .wb_stall_o (wb_stall),
      .pwm_cyc_o  (pwm_cyc),
      .pwm_stb_o  (pwm_stb),
      .pwm_we_o   (pwm_we),
      .pwm_adr_o  (pwm_adr),
      .pwm_dat_o  (pwm_dat),
      .pwm_ack_i  (pwm_ack),
      .pwm_stall_i(pwm_stall),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: what wb_pwm should hold per channel, and what was asked.
   int model_cur[CH];
   int model_tgt[CH];
   int wcount[CH];
   int last_dat[CH];
   int last_adr;

   bit stall_force = 0;
   bit stall_rand  = 0;
   bit ack_hold    = 0;
   bit ack_owed    = 0;

   typedef struct {
      int ch;
      int tgt;
      int div;
      int exp_writes;
      int exp_final;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   function automatic int model_busy();
      for (int c = 0; c < CH; c++) begin
         if (model_cur[c] != model_tgt[c]) return 1;
      end
      return 0;
   endfunction

   function automatic void clear_counts();
      for (int c = 0; c < CH; c++) wcount[c] = 0;
   endfunction

   // Master-side responder and monitor: every accepted request is checked.
   initial begin
      bit acc;
      int a, d, exp_d, exp_ch;
      pwm_ack   = 1'b0;
      pwm_stall = 1'b0;
      forever begin
         @(negedge clk);
         pwm_stall = stall_force || (stall_rand && ($urandom_range(0, 2) == 0));
         pwm_ack   = ack_owed && !ack_hold;
         if (pwm_ack) ack_owed = 0;
         acc = rst_n && pwm_cyc && pwm_stb && !pwm_stall;
         if (acc) begin
            ack_owed = 1;
            a = int'(pwm_adr);
            d = int'(pwm_dat);
            check("pwm_we", pwm_we, 1);
            if (a >= CH) begin
               check("pwm_adr_range", a, 0);
            end else begin
               if (last_adr >= 0) begin
                  exp_ch = -1;
                  for (int k = 1; k <= CH; k++) begin
                     if (exp_ch < 0 && model_cur[(last_adr + k) % CH] != model_tgt[(last_adr + k) % CH])
                        exp_ch = (last_adr + k) % CH;
                  end
                  check("scan_order", a, exp_ch);
               end
               if (model_cur[a] < model_tgt[a]) exp_d = model_cur[a] + 1;
               else if (model_cur[a] > model_tgt[a]) exp_d = model_cur[a] - 1;
               else exp_d = -1;
               check($sformatf("pwm_dat ch%0d", a), d, exp_d);
               model_cur[a] = d;
               last_dat[a]  = d;
               wcount[a]++;
               last_adr = a;
               check("busy_step", busy, model_busy());
            end
         end
      end
   end

   task automatic wb_write(input int adr, input int dat);
      @(negedge clk);
      wb_cyc = 1; wb_stb = 1; wb_we = 1;
      wb_adr = 32'(adr); wb_dat_w = 32'(dat);
      @(negedge clk);
      check($sformatf("wb_ack wr a%0d", adr), wb_ack, 1);
      wb_cyc = 0; wb_stb = 0; wb_we = 0;
      if (adr < CH) begin
         model_tgt[adr] = (dat > FULL) ? FULL : dat;
         last_adr = -1;
      end
   endtask

   task automatic wb_read(input int adr, output int dat);
      @(negedge clk);
      wb_cyc = 1; wb_stb = 1; wb_we = 0;
      wb_adr = 32'(adr);
      @(negedge clk);
      check($sformatf("wb_ack rd a%0d", adr), wb_ack, 1);
      dat = int'(wb_dat_r);
      wb_cyc = 0; wb_stb = 0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check(name, busy, 0);
      repeat (40) @(negedge clk);
   endtask

   initial begin
      int rd, a0, d0, tot, found;
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int rd, a0, d0, tot;
      bit found;
      rst_n = 0; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = 0; wb_dat_w = 0;
      last_adr = -1;
      for (int c = 0; c < CH; c++) begin
         model_cur[c] = 0; model_tgt[c] = 0; last_dat[c] = 0; wcount[c] = 0;
      end

      repeat (3) @(negedge clk);
      check("rst wb_ack", wb_ack, 0);
      check("rst wb_dat", wb_dat_r, 0);
      check("rst wb_stall", wb_stall, 0);
      check("rst pwm_cyc", pwm_cyc, 0);
      check("rst pwm_stb", pwm_stb, 0);
      check("rst pwm_we", pwm_we, 0);
      check("rst pwm_adr", pwm_adr, 0);
      check("rst pwm_dat", pwm_dat, 0);
      check("rst busy", busy, 0);
      rst_n = 1;
      repeat (2) @(negedge clk);

      // Directed fades: {channel, target written, DIV, expected writes, final duty}
      vecs[0] = '{0, 8, 3, 8, 8};
      vecs[1] = '{1, 5, 2, 5, 5};
      vecs[2] = '{1, 3, 0, 2, 3};
      vecs[3] = '{2, 15, 1, 8, 8};
      vecs[4] = '{0, 2, 3, 6, 2};
      vecs[5] = '{2, 8, 0, 0, 8};
      vecs[6] = '{2, 0, 5, 8, 0};

      wb_write(CH, 3);
      wb_write(CH + 1, 1);
      for (int v = 0; v < 7; v++) begin
         clear_counts();
         wb_write(CH, vecs[v].div);
         wb_write(vecs[v].ch, vecs[v].tgt);
         wait_idle($sformatf("vec%0d busy_fall", v));
         tot = 0;
         for (int c = 0; c < CH; c++) if (c != vecs[v].ch) tot += wcount[c];
         check($sformatf("vec%0d writes", v), wcount[vecs[v].ch], vecs[v].exp_writes);
         check($sformatf("vec%0d other_writes", v), tot, 0);
         check($sformatf("vec%0d final", v), last_dat[vecs[v].ch], vecs[v].exp_final);
      end

      // Stall held for several cycles: request must stay frozen and land once.
      clear_counts();
      wb_write(CH, 0);
      stall_force = 1;
      wb_write(0, model_cur[0] + 1);
      found = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (pwm_stb) begin found = 1; break; end
      end
      check("stall stb_seen", pwm_stb, 1);
      a0 = int'(pwm_adr);
      d0 = int'(pwm_dat);
      check("stall adr", a0, 0);
      check("stall dat", d0, model_tgt[0]);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall hold stb", pwm_stb, 1);
         check("stall hold adr", pwm_adr, a0);
         check("stall hold dat", pwm_dat, d0);
      end
      stall_force = 0;
      wait_idle("stall busy_fall");
      check("stall write_once", wcount[0], 1);

      // DIV=0 with all channels stepping: ticks coalesce, no value skipped.
      clear_counts();
      wb_write(0, 7);
      wb_write(1, 0);
      wb_write(2, 6);
      wait_idle("div0 busy_fall");
      check("div0 ch0 writes", wcount[0], 4);
      check("div0 ch1 writes", wcount[1], 3);
      check("div0 ch2 writes", wcount[2], 6);

      // Randomized fades with random stall and DIV.
      for (int it = 0; it < 8; it++) begin
         wb_write(CH + 1, 0);
         repeat (20) @(negedge clk);
         stall_rand = bit'($urandom_range(0, 1));
         wb_write(CH, int'($urandom_range(0, 6)));
         for (int c = 0; c < CH; c++) wb_write(c, int'($urandom_range(0, 15)));
         clear_counts();
         last_adr = -1;
         wb_write(CH + 1, 1);
         wait_idle($sformatf("rand%0d busy_fall", it));
         for (int c = 0; c < CH; c++)
            check($sformatf("rand%0d ch%0d reached", it, c), model_cur[c], model_tgt[c]);
      end
      stall_rand = 0;

`ifdef WB_PWM_FADER_READBACK_EN
      wb_write(CH + 1, 0);
      repeat (20) @(negedge clk);
      wb_write(0, 15);
      wb_read(0, rd);
      check("rb target clamp", rd, (model_cur[0] << BITS) | FULL);
      wb_write(CH, 9);
      wb_read(CH, rd);
      check("rb div", rd, 9);
      wb_read(CH + 1, rd);
      check("rb ctrl", rd, 0);
      wb_read(CH + 2, rd);
      check("rb status", rd, model_busy());
`endif

      // Reset while the master is waiting for its ack.
      wb_write(CH, 0);
      wb_write(CH + 1, 1);
      ack_hold = 1;
      wb_write(1, (model_cur[1] == 0) ? 4 : 0);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (pwm_cyc && !pwm_stb) break;
      end
      check("rstwait in_wait", pwm_cyc && !pwm_stb, 1);
      rst_n = 0;
      #1;
      check("rstwait cyc_drop", pwm_cyc, 0);
      check("rstwait stb_drop", pwm_stb, 0);
      for (int c = 0; c < CH; c++) begin model_cur[c] = 0; model_tgt[c] = 0; end
      ack_owed = 0;
      ack_hold = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      clear_counts();
      repeat (60) @(negedge clk);
      tot = wcount[0] + wcount[1] + wcount[2];
      check("rstwait no_writes", tot, 0);
      check("rstwait busy", busy, 0);
      check("rstwait cyc", pwm_cyc, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
